// File: rtl/vec100_collector_if.sv
// Handshake bundle between a narrow beat source, the collector and the wide downstream consumer.
// master = source/sink side, slave = collector side.
interface vec100_collector_if #(
    parameter int WIDTH = 100,
    parameter int DIN_W = 4,
    parameter int CW    = $clog2(WIDTH / DIN_W)
);
    logic [DIN_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic             abort;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CW-1:0]    beat_cnt;
    logic [15:0]      word_count;

    modport master (
        output s_data, s_valid, abort, m_ready,
        input  s_ready, m_data, m_valid, beat_cnt, word_count
    );

    modport slave (
        input  s_data, s_valid, abort, m_ready,
        output s_ready, m_data, m_valid, beat_cnt, word_count
    );
endinterface

// File: rtl/vec100_collector.sv
// Packs DIN_W-bit beats LSB-first into a registered WIDTH-bit word; word valid the cycle after its last beat.
// Only the final beat stalls while the single-entry output register is held; abort drops the partial word.
module vec100_collector #(
    parameter int WIDTH = 100,
    parameter int DIN_W = 4,
    parameter int BEATS = WIDTH / DIN_W,
    parameter int CW    = $clog2(BEATS)
) (
    input  logic               clk,
    input  logic               reset,
    vec100_collector_if.slave  bus
);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [WIDTH-1:0] asm_q, asm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic [15:0]      wc_q, wc_d;

    logic is_last;
    logic s_rdy;
    logic accept;
    logic handoff;

    assign is_last = (cnt_q == LAST);
    // m_ready reaches s_ready combinationally so a consumed word frees the slot for the final beat at once
    assign s_rdy   = !reset && !bus.abort && !(is_last && vld_q && !bus.m_ready);
    assign accept  = bus.s_valid && s_rdy;
    assign handoff = vld_q && bus.m_ready;

    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        out_d = out_q;
        vld_d = vld_q;
        wc_d  = wc_q;

        if (handoff) begin
            vld_d = 1'b0;
            wc_d  = wc_q + 16'd1;
        end

        if (bus.abort) begin
            asm_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (is_last) begin
                out_d = {bus.s_data, asm_q[WIDTH-DIN_W-1:0]};
                vld_d = 1'b1;
                cnt_d = '0;
            end else begin
                for (int k = 0; k < BEATS; k++) begin
                    if (cnt_q == CW'(k)) begin
                        asm_d[k*DIN_W +: DIN_W] = bus.s_data;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
            wc_q  <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            vld_q <= vld_d;
            wc_q  <= wc_d;
        end
    end

    assign bus.s_ready    = s_rdy;
    assign bus.m_data     = out_q;
    assign bus.m_valid    = vld_q;
    assign bus.beat_cnt   = cnt_q;
    assign bus.word_count = wc_q;
endmodule

// File: doc/vec100_collector.md
# vec100_collector

Stream-to-vector collector that assembles a 100-bit word from narrow DIN_W-bit beats and presents it, fully registered, to the downstream 100-input reduction stage (AND/OR/XOR). It sits between a narrow serial source and the wide combinational reduction logic. A valid/ready handshake on both sides provides backpressure. An abort input discards a partial word.

## Interface

Parameters:
- WIDTH, 100, assembled word width
- DIN_W, 4, beat width; must divide WIDTH exactly
- BEATS, WIDTH/DIN_W (25), derived; beats per word
- CW, $clog2(BEATS) (5), derived; beat counter width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- s_data  input  DIN_W  input beat
- s_valid  input  1  beat valid
- s_ready  output  1  collector can accept a beat this cycle
- abort  input  1  discard the partial word in assembly
- m_data  output  WIDTH  assembled word; feeds the reduction stage `in`
- m_valid  output  1  m_data holds a complete word
- m_ready  input  1  downstream consumes m_data this cycle
- beat_cnt  output  CW  beats already accepted into the current partial word
- word_count  output  16  completed words handed off (m_valid & m_ready); wraps at 16'hFFFF→0

## Operation

- A beat is accepted when s_valid & s_ready. A word is handed off when m_valid & m_ready.
- Packing is LSB first. Beat k (k = 0..BEATS-1) of a word lands in bits [k*DIN_W +: DIN_W].
- Assembly register asm_data plus counter beat_cnt. On a non-final accepted beat, the beat is written into its slot and beat_cnt increments.
- Final beat (beat_cnt == BEATS-1) accepted:
  - The completed word {s_data, asm_data[WIDTH-DIN_W-1:0]} loads into the output register.
  - m_valid is set and beat_cnt returns to 0.
- Output register is single-entry. It holds m_data stable while m_valid & !m_ready.
- s_ready = !reset & !abort & !(beat_cnt == BEATS-1 & m_valid & !m_ready).
  - Non-final beats are always accepted while the output register is occupied.
  - Only the final beat stalls.
  - There is a combinational path from m_ready to s_ready. This is permitted.
- Handoff and final beat in the same cycle: the old word is consumed, the new word loads, and m_valid stays 1. There is no bubble.
- Handoff without a final beat: m_valid clears next cycle.
- abort = 1:
  - beat_cnt is cleared to 0 and asm_data to 0.
  - s_ready is held 0, so any coincident s_valid beat is discarded.
  - The output register, m_valid and word_count are unaffected.
  - Downstream handoff proceeds normally.
- Unused asm_data slots hold zero after reset or abort. This is not observable on m_data, because every slot is rewritten before load.
- word_count increments by 1 on each handoff, modulo 2^16.

## Timing

- Reset values (cycle after reset sampled high): m_valid=0, m_data=0, beat_cnt=0, word_count=0. asm_data=0. s_ready=0 while reset is high.
- Reset mid-word or with a pending output: everything is cleared and the partial word is lost. s_ready=1 in the first cycle after reset deasserts.
- Latency: m_valid and m_data are valid in the cycle after the final beat is accepted.
- Throughput: one beat per cycle sustained. One word every BEATS cycles with m_ready held high.
- beat_cnt updates the cycle after each acceptance and reads 0 immediately after a final beat.
- Outputs m_data, m_valid, beat_cnt and word_count are all registers. s_ready is the only combinational output.
- Downstream reduction results are valid in the same cycle as m_valid, since the reduction stage is combinational.

## Test plan

- Reset, then 25 beats of 4'hF with m_ready=1:
  - m_data = 100'hF…F and m_valid=1 exactly one cycle after beat 25.
  - Downstream out_and=1, out_xor=0. word_count=1.
- Beat k carries k[3:0] for k=0..24:
  - m_data[3:0]=0, m_data[63:60]=F, m_data[67:64]=0, m_data[99:96]=8.
  - beat_cnt steps 0→24→0.
- Backpressure: m_ready=0, 50 consecutive beats offered.
  - Word 1 is held stable. Beats 26–49 are accepted and beat 50 stalls (s_ready=0).
  - Raise m_ready one cycle: word 1 is handed off, word 2 loads in the same cycle, m_valid stays 1, word_count=1.
- Abort after 10 beats, with s_valid=1 in the abort cycle:
  - beat_cnt=0 and that beat is dropped.
  - Then 25 beats of 4'hA: m_data = 100'hA…A, with no residue from the aborted beats.
- Reset asserted at beat 12 while a completed word is pending (m_ready=0):
  - Next cycle m_valid=0, m_data=0, beat_cnt=0, word_count=0.
  - A fresh 25-beat word then completes normally.
- Sustained streaming: 4 words back-to-back with m_ready=1.
  - s_ready stays 1 throughout. m_valid pulses once per 25 cycles. word_count=4.
